// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: direction counter
// encoding, saturating counter step, and statistics ceiling.
package bp_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } counter_t;

   localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

   function automatic counter_t sat_next(counter_t c, logic taken);
      counter_t n;
      n = c;
      case (c)
         STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  n = taken ? STRONG_T : WEAK_T;
         default:   n = STRONG_NT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bp_counter_table.sv
// ENTRIES-deep table of 2-bit direction counters with one combinational
// read port and one registered write port (saturate or allocate-init).
module bp_counter_table
   import bp_pkg::*;
#(
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [IDX_W-1:0] rd_idx,
   output counter_t         rd_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken,
   input  logic             wr_alloc
);

   counter_t ctr [ENTRIES];

   assign rd_ctr = ctr[rd_idx];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= STRONG_NT;
      end else if (wr_en) begin
         // a fresh allocation starts weak in the resolved direction
         if (wr_alloc) ctr[wr_idx] <= wr_taken ? WEAK_T : WEAK_NT;
         else          ctr[wr_idx] <= sat_next(ctr[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/br_predictor_btb.sv
// Tagged direct-mapped BTB with 2-bit direction counters and branch /
// mispredict statistics. Define GSHARE_EN to index counters by idx ^ GHR.
module br_predictor_btb
   import bp_pkg::*;
#(
   parameter  int ENTRIES = 16,
   parameter  int HIST_W  = 4,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [31:0]       lookup_pc,
   output logic              hit,
   output logic              predict,
   output logic [31:0]       pred_target,
   output logic [HIST_W-1:0] pred_hist,
   input  logic              pc_en,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_pred,
   input  logic [HIST_W-1:0] upd_hist,
   output logic [31:0]       br_count,
   output logic [31:0]       mispred_count
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic             valid   [ENTRIES];
   logic [TAG_W-1:0] tags    [ENTRIES];
   logic [31:0]      targets [ENTRIES];

   logic [IDX_W-1:0] l_idx, u_idx, ctr_rd_idx, ctr_wr_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic             upd, upd_hit, ctr_alloc;
   counter_t         ctr_rd;

   assign l_idx = lookup_pc[IDX_W+1:2];
   assign l_tag = lookup_pc[31:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[31:IDX_W+2];

   assign upd     = upd_valid & pc_en;
   assign upd_hit = valid[u_idx] && (tags[u_idx] == u_tag);

   assign hit         = valid[l_idx] && (tags[l_idx] == l_tag);
   assign predict     = hit && ((ctr_rd == WEAK_T) || (ctr_rd == STRONG_T));
   assign pred_target = hit ? targets[l_idx] : 32'h0;

   logic unused_bits;

`ifdef GSHARE_EN
   logic [HIST_W-1:0] ghr;

   assign ctr_rd_idx  = l_idx ^ IDX_W'(ghr);
   assign ctr_wr_idx  = u_idx ^ IDX_W'(upd_hist);
   assign ctr_alloc   = 1'b0;
   assign pred_hist   = ghr;
   assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)    ghr <= '0;
      else if (upd) ghr <= {ghr[HIST_W-2:0], upd_taken};
   end
`else
   assign ctr_rd_idx  = l_idx;
   assign ctr_wr_idx  = u_idx;
   assign ctr_alloc   = ~upd_hit;
   assign pred_hist   = '0;
   assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_hist};
`endif

   bp_counter_table #(.ENTRIES(ENTRIES)) u_ctr (
      .CLK      (CLK),
      .nRST     (nRST),
      .rd_idx   (ctr_rd_idx),
      .rd_ctr   (ctr_rd),
      .wr_en    (upd),
      .wr_idx   (ctr_wr_idx),
      .wr_taken (upd_taken),
      .wr_alloc (ctr_alloc)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]   <= 1'b0;
            tags[i]    <= '0;
            targets[i] <= '0;
         end
      end else if (upd) begin
         if (upd_hit) begin
            if (upd_taken) targets[u_idx] <= upd_target;
         end else begin
            valid[u_idx]   <= 1'b1;
            tags[u_idx]    <= u_tag;
            targets[u_idx] <= upd_target;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (upd) begin
         if (br_count != STAT_MAX) br_count <= br_count + 32'd1;
         if ((upd_pred != upd_taken) && (mispred_count != STAT_MAX))
            mispred_count <= mispred_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_br_predictor_btb.sv
// Directed bench for br_predictor_btb: allocation, counter saturation,
// aliasing, pc_en gating, same-cycle read/write and async reset.
module tb_br_predictor_btb;

   logic        CLK, nRST;
   logic [31:0] lookup_pc;
   logic        hit, predict;
   logic [31:0] pred_target;
   logic [3:0]  pred_hist;
   logic        pc_en, upd_valid, upd_taken, upd_pred;
   logic [31:0] upd_pc, upd_target;
   logic [3:0]  upd_hist;
   logic [31:0] br_count, mispred_count;

   int checks = 0;
   int errors = 0;

   br_predictor_btb #(.ENTRIES(16), .HIST_W(4)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .lookup_pc     (lookup_pc),
      .hit           (hit),
      .predict       (predict),
      .pred_target   (pred_target),
      .pred_hist     (pred_hist),
      .pc_en         (pc_en),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target),
      .upd_pred      (upd_pred),
      .upd_hist      (upd_hist),
      .br_count      (br_count),
      .mispred_count (mispred_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic look(input logic [31:0] pc, input logic eh, input logic ep,
                       input logic [31:0] et, input string tag);
      lookup_pc = pc;
      #1;
      chk({tag, ".hit"}, 32'(hit), 32'(eh));
      chk({tag, ".predict"}, 32'(predict), 32'(ep));
      chk({tag, ".target"}, pred_target, et);
   endtask

   task automatic stats(input logic [31:0] eb, input logic [31:0] em, input string tag);
      chk({tag, ".br"}, br_count, eb);
      chk({tag, ".mis"}, mispred_count, em);
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic pr, input logic [3:0] hs, input logic en);
      @(negedge CLK);
      upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred = pr;
      upd_hist = hs; pc_en = en; upd_valid = 1'b1;
      @(negedge CLK);
      upd_valid = 1'b0; pc_en = 1'b1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
   endtask

   initial begin
      nRST = 1'b0; lookup_pc = 32'h40; pc_en = 1'b1; upd_valid = 1'b0;
      upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0; upd_hist = '0;
      do_reset();

      look(32'h40, 0, 0, 32'h0, "reset");
      stats(0, 0, "reset");
      chk("reset.hist", 32'(pred_hist), 32'h0);

`ifdef GSHARE_EN
      // alternating T/NT at 0x40; counters at idx^GHR learn the pattern
      for (int k = 0; k < 20; k++) begin
         logic p;
         logic [3:0] h;
         logic [31:0] mis_before;
         @(negedge CLK);
         lookup_pc = 32'h40;
         #1;
         p = predict; h = pred_hist; mis_before = mispred_count;
         if (k >= 4) chk($sformatf("gs.hist%0d", k), 32'(h), (k % 2 == 0) ? 32'hA : 32'h5);
         upd(32'h40, (k % 2 == 0), 32'h100, p, h, 1'b1);
         if (k >= 10) chk($sformatf("gs.mis%0d", k), mispred_count, mis_before);
      end
      stats(20, mispred_count, "gs.final");
`else
      // allocate taken -> WEAK_T
      upd(32'h40, 1, 32'h100, 0, 0, 1);
      look(32'h40, 1, 1, 32'h100, "alloc");
      stats(1, 1, "alloc");

      // four not-taken: WT->WNT->SNT->SNT->SNT, target untouched
      upd(32'h40, 0, 32'hDEAD, 0, 0, 1);
      look(32'h40, 1, 0, 32'h100, "nt1");
      for (int i = 0; i < 3; i++) upd(32'h40, 0, 32'hBEEF, 0, 0, 1);
      look(32'h40, 1, 0, 32'h100, "nt4");
      stats(5, 1, "nt4");

      // two taken: SNT->WNT (still NT), WNT->WT (taken, target rewritten)
      upd(32'h40, 1, 32'h180, 0, 0, 1);
      look(32'h40, 1, 0, 32'h180, "t1");
      upd(32'h40, 1, 32'h200, 0, 0, 1);
      look(32'h40, 1, 1, 32'h200, "t2");
      stats(7, 3, "t2");

      // alias: 0x80 shares idx 0 with a different tag
      upd(32'h80, 1, 32'h300, 0, 0, 1);
      look(32'h40, 0, 0, 32'h0, "alias40");
      look(32'h80, 1, 1, 32'h300, "alias80");
      upd(32'h40, 0, 32'h140, 1, 0, 1);
      look(32'h40, 1, 0, 32'h140, "realloc40");
      look(32'h80, 0, 0, 32'h0, "evict80");
      stats(9, 5, "alias");

      // pc_en low: nothing moves
      upd(32'h40, 1, 32'h999, 0, 0, 0);
      look(32'h40, 1, 0, 32'h140, "pcen0");
      stats(9, 5, "pcen0");

      // same-cycle lookup and update: old contents until the edge
      @(negedge CLK);
      upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h180; upd_pred = 1'b0;
      pc_en = 1'b1; upd_valid = 1'b1;
      look(32'h40, 1, 0, 32'h140, "same.pre");
      @(negedge CLK);
      upd_valid = 1'b0;
      look(32'h40, 1, 1, 32'h180, "same.post");
      stats(10, 6, "same");

      look(32'h44, 0, 0, 32'h0, "idx1");

      // reset during an update: reset wins
      @(negedge CLK);
      upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'h400; upd_pred = 1'b0;
      upd_valid = 1'b1; pc_en = 1'b1;
      #2 nRST = 1'b0;
      @(negedge CLK);
      upd_valid = 1'b0;
      look(32'h44, 0, 0, 32'h0, "rstmid44");
      look(32'h40, 0, 0, 32'h0, "rstmid40");
      stats(0, 0, "rstmid");
      nRST = 1'b1;
      @(negedge CLK);
      look(32'h44, 0, 0, 32'h0, "rstrel");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
